// File: rtl/uart_rx_cfg_if.sv
// Receiver-side bundle: serial line in, received word and per-frame status out.
interface uart_rx_cfg_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic                 rx;
    logic                 data_en;
    logic [DATA_BITS-1:0] data_out;
    logic                 parity_err;
    logic                 frame_err;
    logic                 break_det;
    logic                 busy;

    // Receiver side.
    modport master (
        input  rx,
        output data_en,
        output data_out,
        output parity_err,
        output frame_err,
        output break_det,
        output busy
    );

    // Line driver / consumer side.
    modport slave (
        output rx,
        input  data_en,
        input  data_out,
        input  parity_err,
        input  frame_err,
        input  break_det,
        input  busy
    );
endinterface

// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver: oversampled 3-sample majority vote, configurable
// data width, parity and stop bits, with per-frame parity/framing/break status.
module uart_rx_cfg #(
    parameter int unsigned CLK_DIV    = 326,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1
) (
    input logic           clk_i,
    input logic           rst_ni,
    uart_rx_cfg_if.master bus
);

    localparam int unsigned M     = OVERSAMPLE / 2;
    localparam int unsigned PresW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned SubW  = $clog2(OVERSAMPLE);
    localparam int unsigned BitW  = $clog2(DATA_BITS);

    localparam logic [PresW-1:0] PresLast = PresW'(CLK_DIV - 1);
    localparam logic [SubW-1:0]  SubLast  = SubW'(OVERSAMPLE - 1);
    localparam logic [SubW-1:0]  SubV0    = SubW'(M - 1);
    localparam logic [SubW-1:0]  SubV1    = SubW'(M);
    localparam logic [SubW-1:0]  SubV2    = SubW'(M + 1);
    localparam logic [BitW-1:0]  BitLast  = BitW'(DATA_BITS - 1);
    localparam logic             StopLast = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        StArm,
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    state_e state_q, state_d;

    // Synchronizer and edge history.
    logic sync_q, rxs_q, rxs_prev_q;
    logic fall;

    // Oversampling timebase.
    logic [PresW-1:0] presc_q, presc_d;
    logic [SubW-1:0]  sub_q, sub_d;
    logic             tick;
    logic             start_det;
    logic             vote_now;
    logic             bit_end;

    // Majority vote samples.
    logic s0_q, s1_q;
    logic vote;

    // Frame assembly.
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [BitW-1:0]      bit_q, bit_d;
    logic                 stop_q, stop_d;
    logic                 par_q, par_d;
    logic                 ferr_q, ferr_d;

    // Delivered word and status.
    logic                 data_en_q, data_en_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 perr_out_q, perr_out_d;
    logic                 ferr_out_q, ferr_out_d;
    logic                 brk_q, brk_d;

    // Frame-end helpers.
    logic ones;
    logic perr_now;
    logic ferr_now;

    // Two-flop synchronizer; idle-high reset so reset never fakes a falling edge.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q     <= 1'b1;
            rxs_q      <= 1'b1;
            rxs_prev_q <= 1'b1;
        end else begin
            sync_q     <= bus.rx;
            rxs_q      <= sync_q;
            rxs_prev_q <= rxs_q;
        end
    end

    assign fall      = rxs_prev_q & ~rxs_q;
    assign start_det = (state_q == StIdle) & fall;
    assign tick      = (presc_q == PresLast);
    assign vote_now  = tick & (sub_q == SubV2);
    assign bit_end   = tick & (sub_q == SubLast);
    assign vote      = (s0_q & s1_q) | (s0_q & rxs_q) | (s1_q & rxs_q);

    // Prescaler and sub-bit counter, realigned to every accepted start edge.
    always_comb begin
        presc_d = presc_q;
        sub_d   = sub_q;
        if (start_det) begin
            presc_d = '0;
            sub_d   = '0;
        end else if (tick) begin
            presc_d = '0;
            sub_d   = (sub_q == SubLast) ? '0 : sub_q + SubW'(1);
        end else begin
            presc_d = presc_q + PresW'(1);
        end
    end

    // Timebase registers and the first two vote samples of each bit.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            presc_q <= '0;
            sub_q   <= '0;
            s0_q    <= 1'b0;
            s1_q    <= 1'b0;
        end else begin
            presc_q <= presc_d;
            sub_q   <= sub_d;
            if (tick && (sub_q == SubV0)) begin
                s0_q <= rxs_q;
            end
            if (tick && (sub_q == SubV1)) begin
                s1_q <= rxs_q;
            end
        end
    end

    // Status for the frame being closed: parity over data plus parity bit.
    always_comb begin
        ones = ^{shift_q, par_q};
        if (PARITY == 1) begin
            perr_now = ~ones;
        end else if (PARITY == 2) begin
            perr_now = ones;
        end else begin
            perr_now = 1'b0;
        end
        ferr_now = ferr_q | ~vote;
    end

    // Frame FSM: next state, frame assembly and delivery.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_d      = bit_q;
        stop_d     = stop_q;
        par_d      = par_q;
        ferr_d     = ferr_q;
        data_en_d  = 1'b0;
        data_d     = data_q;
        perr_out_d = perr_out_q;
        ferr_out_d = ferr_out_q;
        brk_d      = brk_q;

        unique case (state_q)
            StArm: begin
                if (rxs_q) begin
                    state_d = StIdle;
                end
            end
            StIdle: begin
                if (fall) begin
                    state_d = StStart;
                    bit_d   = '0;
                    stop_d  = 1'b0;
                    par_d   = 1'b0;
                    ferr_d  = 1'b0;
                end
            end
            StStart: begin
                if (vote_now && vote) begin
                    // Glitch: line was high mid-bit, not a real start bit.
                    state_d = StIdle;
                end else if (bit_end) begin
                    state_d = StData;
                end
            end
            StData: begin
                if (vote_now) begin
                    shift_d = {vote, shift_q[DATA_BITS-1:1]};
                end
                if (bit_end) begin
                    if (bit_q == BitLast) begin
                        state_d = (PARITY != 0) ? StParity : StStop;
                    end else begin
                        bit_d = bit_q + BitW'(1);
                    end
                end
            end
            StParity: begin
                if (vote_now) begin
                    par_d = vote;
                end
                if (bit_end) begin
                    state_d = StStop;
                end
            end
            StStop: begin
                if (vote_now) begin
                    if (stop_q == StopLast) begin
                        // Close at the final vote so a back-to-back start is not missed.
                        data_en_d  = 1'b1;
                        data_d     = shift_q;
                        perr_out_d = perr_now;
                        ferr_out_d = ferr_now;
                        brk_d      = ferr_now & (shift_q == '0) & ~par_q;
                        // After a framing error wait for line-high so a held break is
                        // not taken as a new start.
                        state_d    = ferr_now ? StArm : StIdle;
                    end else begin
                        ferr_d = ferr_now;
                    end
                end
                if (bit_end && (stop_q != StopLast)) begin
                    stop_d = 1'b1;
                end
            end
            default: begin
                state_d = StArm;
            end
        endcase
    end

    // FSM, frame and output registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= StArm;
            shift_q    <= '0;
            bit_q      <= '0;
            stop_q     <= 1'b0;
            par_q      <= 1'b0;
            ferr_q     <= 1'b0;
            data_en_q  <= 1'b0;
            data_q     <= '0;
            perr_out_q <= 1'b0;
            ferr_out_q <= 1'b0;
            brk_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_q      <= bit_d;
            stop_q     <= stop_d;
            par_q      <= par_d;
            ferr_q     <= ferr_d;
            data_en_q  <= data_en_d;
            data_q     <= data_d;
            perr_out_q <= perr_out_d;
            ferr_out_q <= ferr_out_d;
            brk_q      <= brk_d;
        end
    end

    assign bus.data_en    = data_en_q;
    assign bus.data_out   = data_q;
    assign bus.parity_err = perr_out_q;
    assign bus.frame_err  = ferr_out_q;
    assign bus.break_det  = brk_q;
    assign bus.busy       = (state_q == StStart) | (state_q == StData) |
                            (state_q == StParity) | (state_q == StStop);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: 8N1, 7E1 and 8N2 instances at 32 clocks per bit.
`timescale 1ns/1ps
module tb_uart_rx_cfg;

    localparam int unsigned CLK_DIV    = 4;
    localparam int unsigned OVERSAMPLE = 8;
    localparam real         CLK_NS     = 10.0;
    localparam real         BIT_NS     = 320.0;
    localparam real         FAST_NS    = 313.7;   // 102 % of nominal rate

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    uart_rx_cfg_if #(.DATA_BITS(8)) if_8n1 ();
    uart_rx_cfg_if #(.DATA_BITS(7)) if_7e1 ();
    uart_rx_cfg_if #(.DATA_BITS(8)) if_8n2 ();

    uart_rx_cfg #(.CLK_DIV(CLK_DIV), .OVERSAMPLE(OVERSAMPLE), .DATA_BITS(8), .PARITY(0),
                  .STOP_BITS(1)) u_8n1 (.clk_i(clk), .rst_ni(rst_n), .bus(if_8n1.master));
    uart_rx_cfg #(.CLK_DIV(CLK_DIV), .OVERSAMPLE(OVERSAMPLE), .DATA_BITS(7), .PARITY(2),
                  .STOP_BITS(1)) u_7e1 (.clk_i(clk), .rst_ni(rst_n), .bus(if_7e1.master));
    uart_rx_cfg #(.CLK_DIV(CLK_DIV), .OVERSAMPLE(OVERSAMPLE), .DATA_BITS(8), .PARITY(0),
                  .STOP_BITS(2)) u_8n2 (.clk_i(clk), .rst_ni(rst_n), .bus(if_8n2.master));

    // Strobe capture: {break, frame_err, parity_err, data (9 bits)}.
    logic [11:0] q_8n1[$];
    logic [11:0] q_7e1[$];
    logic [11:0] q_8n2[$];
    realtime     t_en_8n1;

    // Capture every strobe away from the active edge.
    always @(negedge clk) begin
        if (if_8n1.data_en === 1'b1) begin
            q_8n1.push_back({if_8n1.break_det, if_8n1.frame_err, if_8n1.parity_err,
                             1'b0, if_8n1.data_out});
            t_en_8n1 = $realtime;
        end
        if (if_7e1.data_en === 1'b1) begin
            q_7e1.push_back({if_7e1.break_det, if_7e1.frame_err, if_7e1.parity_err,
                             2'b00, if_7e1.data_out});
        end
        if (if_8n2.data_en === 1'b1) begin
            q_8n2.push_back({if_8n2.break_det, if_8n2.frame_err, if_8n2.parity_err,
                             1'b0, if_8n2.data_out});
        end
    end

    task automatic drive_rx(input int inst, input logic v);
        case (inst)
            0:       if_8n1.rx = v;
            1:       if_7e1.rx = v;
            default: if_8n2.rx = v;
        endcase
    endtask

    // par < 0 means no parity bit.
    task automatic send_frame(input int inst, input logic [8:0] data, input int nbits,
                              input int par, input int nstop, input real bit_ns);
        drive_rx(inst, 1'b0);
        #(bit_ns);
        for (int i = 0; i < nbits; i++) begin
            drive_rx(inst, data[i]);
            #(bit_ns);
        end
        if (par >= 0) begin
            drive_rx(inst, par[0]);
            #(bit_ns);
        end
        for (int i = 0; i < nstop; i++) begin
            drive_rx(inst, 1'b1);
            #(bit_ns);
        end
    endtask

    task automatic idle_bits(input int n);
        #(BIT_NS * n);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive_rx(0, 1'b1);
        drive_rx(1, 1'b1);
        drive_rx(2, 1'b1);
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if ({if_8n1.data_en, if_8n1.busy, if_8n1.parity_err, if_8n1.frame_err,
             if_8n1.break_det} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags_8n1: got %b expected 00000", {if_8n1.data_en,
                     if_8n1.busy, if_8n1.parity_err, if_8n1.frame_err, if_8n1.break_det});
        end
        checks++;
        if (if_8n1.data_out !== 8'h00) begin
            failures++;
            $display("FAIL reset_data_8n1: got %h expected 00", if_8n1.data_out);
        end
        checks++;
        if ({if_7e1.data_en, if_7e1.busy, if_7e1.parity_err, if_7e1.data_out} !== 10'h0) begin
            failures++;
            $display("FAIL reset_7e1: got %h expected 000", {if_7e1.data_en, if_7e1.busy,
                     if_7e1.parity_err, if_7e1.data_out});
        end
        checks++;
        if ({if_8n2.data_en, if_8n2.busy, if_8n2.frame_err, if_8n2.data_out} !== 11'h0) begin
            failures++;
            $display("FAIL reset_8n2: got %h expected 000", {if_8n2.data_en, if_8n2.busy,
                     if_8n2.frame_err, if_8n2.data_out});
        end
    endtask

    task automatic test_8n1_frame();
        realtime t_fall;
        real     lat;
        logic [11:0] e;
        @(negedge clk);
        t_fall = $realtime;
        send_frame(0, 9'h0A5, 8, -1, 1, BIT_NS);
        idle_bits(2);
        checks++;
        if (q_8n1.size() != 1) begin
            failures++;
            $display("FAIL 8n1_count: got %0d strobes expected 1", q_8n1.size());
        end
        e = 12'hfff;
        if (q_8n1.size() > 0) e = q_8n1.pop_front();
        checks++;
        if (e !== 12'h0A5) begin
            failures++;
            $display("FAIL 8n1_word: got %h expected 0a5", e);
        end
        lat = (t_en_8n1 - t_fall) / CLK_NS;
        checks++;
        if (lat < 314.0 || lat > 316.0) begin
            failures++;
            $display("FAIL 8n1_latency: got %0.1f clocks expected 315 +-1", lat);
        end
        q_8n1.delete();
    endtask

    task automatic test_parity();
        logic [11:0] e;
        // 0x41 has two ones: even parity bit 0 is correct, 1 is wrong.
        send_frame(1, 9'h041, 7, 0, 1, BIT_NS);
        idle_bits(1);
        e = 12'hfff;
        if (q_7e1.size() > 0) e = q_7e1.pop_front();
        checks++;
        if (e !== 12'h041) begin
            failures++;
            $display("FAIL 7e1_good_parity: got %h expected 041", e);
        end
        send_frame(1, 9'h041, 7, 1, 1, BIT_NS);
        idle_bits(1);
        e = 12'hfff;
        if (q_7e1.size() > 0) e = q_7e1.pop_front();
        checks++;
        if (e !== 12'h241) begin
            failures++;
            $display("FAIL 7e1_bad_parity: got %h expected 241", e);
        end
        checks++;
        if (q_7e1.size() != 0) begin
            failures++;
            $display("FAIL 7e1_extra: got %0d extra strobes expected 0", q_7e1.size());
        end
        q_7e1.delete();
    endtask

    task automatic test_glitch();
        logic [11:0] e;
        @(negedge clk);
        drive_rx(0, 1'b0);
        repeat (5) @(negedge clk);
        checks++;
        if (if_8n1.busy !== 1'b1) begin
            failures++;
            $display("FAIL glitch_busy_high: got %b expected 1", if_8n1.busy);
        end
        repeat (3) @(negedge clk);
        drive_rx(0, 1'b1);
        repeat (24) @(negedge clk);
        checks++;
        if (if_8n1.busy !== 1'b0) begin
            failures++;
            $display("FAIL glitch_busy_low: got %b expected 0", if_8n1.busy);
        end
        idle_bits(2);
        checks++;
        if (q_8n1.size() != 0) begin
            failures++;
            $display("FAIL glitch_strobe: got %0d strobes expected 0", q_8n1.size());
        end
        q_8n1.delete();
        send_frame(0, 9'h0C3, 8, -1, 1, BIT_NS);
        idle_bits(1);
        e = 12'hfff;
        if (q_8n1.size() > 0) e = q_8n1.pop_front();
        checks++;
        if (e !== 12'h0C3) begin
            failures++;
            $display("FAIL glitch_recover: got %h expected 0c3", e);
        end
        q_8n1.delete();
    endtask

    task automatic test_break();
        logic [11:0] e;
        @(negedge clk);
        drive_rx(0, 1'b0);
        #(BIT_NS * 20);
        checks++;
        if (q_8n1.size() != 1) begin
            failures++;
            $display("FAIL break_count: got %0d strobes expected 1", q_8n1.size());
        end
        e = 12'hfff;
        if (q_8n1.size() > 0) e = q_8n1.pop_front();
        checks++;
        if (e !== 12'hC00) begin
            failures++;
            $display("FAIL break_word: got %h expected c00", e);
        end
        drive_rx(0, 1'b1);
        idle_bits(3);
        checks++;
        if (q_8n1.size() != 0) begin
            failures++;
            $display("FAIL break_rearm: got %0d extra strobes expected 0", q_8n1.size());
        end
        q_8n1.delete();
        send_frame(0, 9'h05A, 8, -1, 1, BIT_NS);
        idle_bits(1);
        e = 12'hfff;
        if (q_8n1.size() > 0) e = q_8n1.pop_front();
        checks++;
        if (e !== 12'h05A) begin
            failures++;
            $display("FAIL break_next_frame: got %h expected 05a", e);
        end
        q_8n1.delete();
    endtask

    task automatic test_back_to_back();
        logic [11:0] exp_q[3];
        logic [11:0] e;
        exp_q[0] = 12'h000;
        exp_q[1] = 12'h0FF;
        exp_q[2] = 12'h03C;
        @(negedge clk);
        send_frame(2, 9'h000, 8, -1, 2, FAST_NS);
        send_frame(2, 9'h0FF, 8, -1, 2, FAST_NS);
        send_frame(2, 9'h03C, 8, -1, 2, FAST_NS);
        idle_bits(2);
        checks++;
        if (q_8n2.size() != 3) begin
            failures++;
            $display("FAIL b2b_count: got %0d strobes expected 3", q_8n2.size());
        end
        for (int i = 0; i < 3; i++) begin
            e = 12'hfff;
            if (q_8n2.size() > 0) e = q_8n2.pop_front();
            checks++;
            if (e !== exp_q[i]) begin
                failures++;
                $display("FAIL b2b_frame%0d: got %h expected %h", i, e, exp_q[i]);
            end
        end
        q_8n2.delete();
    endtask

    task automatic test_reset_mid_frame();
        logic [11:0] e;
        @(negedge clk);
        // Start bit, then abort the sender mid data bit 0 (a 1) of 0x55.
        drive_rx(0, 1'b0);
        #(BIT_NS);
        drive_rx(0, 1'b1);
        #(BIT_NS / 2);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if ({if_8n1.data_en, if_8n1.busy, if_8n1.frame_err, if_8n1.data_out} !== 11'h0) begin
            failures++;
            $display("FAIL midreset_8n1_outputs: got %h expected 000", {if_8n1.data_en,
                     if_8n1.busy, if_8n1.frame_err, if_8n1.data_out});
        end
        checks++;
        if (if_8n2.data_out !== 8'h00) begin
            failures++;
            $display("FAIL midreset_8n2_data: got %h expected 00", if_8n2.data_out);
        end
        idle_bits(12);
        checks++;
        if (q_8n1.size() != 0) begin
            failures++;
            $display("FAIL midreset_strobe: got %0d strobes expected 0", q_8n1.size());
        end
        q_8n1.delete();
        send_frame(0, 9'h012, 8, -1, 1, BIT_NS);
        idle_bits(1);
        e = 12'hfff;
        if (q_8n1.size() > 0) e = q_8n1.pop_front();
        checks++;
        if (e !== 12'h012) begin
            failures++;
            $display("FAIL midreset_next_frame: got %h expected 012", e);
        end
    endtask

    initial begin
        test_reset();
        test_8n1_frame();
        test_parity();
        test_glitch();
        test_break();
        test_back_to_back();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Bound the whole run.
    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
